// File: rtl/triangle_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_loader_if
//  Description : Host word stream and rasterizer triangle handshake bundle
//                for triangle_loader. The master side is the host/consumer
//                pair; the slave side is the loader itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface triangle_loader_if #(
    parameter int COLOR_BITS = 24
);
    logic [31:0]           data_in;
    logic                  data_ready;
    logic                  data_read;
    logic [95:0]           triangle;
    logic [COLOR_BITS-1:0] color;
    logic                  tri_ready;
    logic                  tri_read;

    modport master (
        output data_in, data_ready, tri_read,
        input  data_read, triangle, color, tri_ready
    );

    modport slave (
        input  data_in, data_ready, tri_read,
        output data_read, triangle, color, tri_ready
    );
endinterface
`default_nettype wire

// File: rtl/triangle_loader.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_loader
//  Description : Assembles 4-word host packets (V0, V1, V2, color) into one
//                triangle plus color and presents them on the tri_ready /
//                tri_read handshake. An assembly slot behind the output slot
//                lets the next packet be collected while the current one
//                waits, so up to two complete triangles are buffered.
//                Optional feature macro: DEGENERATE_CULL_EN - drops packets
//                with two vertices sharing (x, y) and counts them on
//                cull_count (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module triangle_loader #(
    parameter int COLOR_BITS = 24
) (
    input  wire logic          clk,
    input  wire logic          n_rst,
    triangle_loader_if.slave   bus,
    output logic               busy
`ifdef DEGENERATE_CULL_EN
    ,
    output logic [15:0]        cull_count
`endif
);

    localparam logic [1:0]  LAST_WORD = 2'd3;
    localparam logic [15:0] CULL_MAX  = 16'hFFFF;

    logic [1:0]            word_cnt_q,  word_cnt_d;
    logic [95:0]           asm_tri_q,   asm_tri_d;
    logic [COLOR_BITS-1:0] asm_color_q, asm_color_d;
    logic                  asm_full_q,  asm_full_d;
    logic [95:0]           out_tri_q,   out_tri_d;
    logic [COLOR_BITS-1:0] out_color_q, out_color_d;
    logic                  tri_ready_q, tri_ready_d;

    logic                  accept;
    logic                  pkt_done;
    logic                  pkt_fwd;
    logic                  release_out;
    logic                  degenerate;
    logic [COLOR_BITS-1:0] new_color;

    // Cull check looks only at the three stored vertex words; word 3 is color.
`ifdef DEGENERATE_CULL_EN
    logic [15:0] cull_count_q, cull_count_d;

    always_comb begin
        degenerate = (asm_tri_q[31:12] == asm_tri_q[63:44]) ||
                     (asm_tri_q[31:12] == asm_tri_q[95:76]) ||
                     (asm_tri_q[63:44] == asm_tri_q[95:76]);
    end
`else
    always_comb begin
        degenerate = 1'b0;
    end
`endif

    // Handshake decode: a packet completes when word 3 is accepted.
    always_comb begin
        accept      = bus.data_ready && !asm_full_q;
        pkt_done    = accept && (word_cnt_q == LAST_WORD);
        pkt_fwd     = pkt_done && !degenerate;
        release_out = tri_ready_q && bus.tri_read;
        new_color   = bus.data_in[COLOR_BITS-1:0];
    end

    // Next-state: word assembly, then output slot / assembly slot movement.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        asm_tri_d   = asm_tri_q;
        asm_color_d = asm_color_q;
        asm_full_d  = asm_full_q;
        out_tri_d   = out_tri_q;
        out_color_d = out_color_q;
        tri_ready_d = tri_ready_q;

        if (accept) begin
            word_cnt_d = word_cnt_q + 2'd1;
            if (word_cnt_q != LAST_WORD) begin
                asm_tri_d[32*word_cnt_q +: 32] = bus.data_in;
            end
        end

        if (release_out) begin
            if (asm_full_q) begin
                // Parked packet moves up; accept is blocked so none can complete.
                out_tri_d   = asm_tri_q;
                out_color_d = asm_color_q;
                asm_full_d  = 1'b0;
            end else if (pkt_fwd) begin
                out_tri_d   = asm_tri_q;
                out_color_d = new_color;
            end else begin
                tri_ready_d = 1'b0;
            end
        end else if (pkt_fwd) begin
            if (!tri_ready_q) begin
                out_tri_d   = asm_tri_q;
                out_color_d = new_color;
                tri_ready_d = 1'b1;
            end else begin
                // Output occupied: park the packet and stall the host.
                asm_color_d = new_color;
                asm_full_d  = 1'b1;
            end
        end
    end

`ifdef DEGENERATE_CULL_EN
    // Saturating count of dropped degenerate packets.
    always_comb begin
        cull_count_d = cull_count_q;
        if (pkt_done && degenerate && (cull_count_q != CULL_MAX)) begin
            cull_count_d = cull_count_q + 16'd1;
        end
    end

    // Cull counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cull_count_q <= 16'd0;
        end else begin
            cull_count_q <= cull_count_d;
        end
    end

    assign cull_count = cull_count_q;
`endif

    // Main state registers; reset discards any partial or buffered packet.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            word_cnt_q  <= 2'd0;
            asm_tri_q   <= '0;
            asm_color_q <= '0;
            asm_full_q  <= 1'b0;
            out_tri_q   <= '0;
            out_color_q <= '0;
            tri_ready_q <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            asm_tri_q   <= asm_tri_d;
            asm_color_q <= asm_color_d;
            asm_full_q  <= asm_full_d;
            out_tri_q   <= out_tri_d;
            out_color_q <= out_color_d;
            tri_ready_q <= tri_ready_d;
        end
    end

    assign bus.data_read = accept;
    assign bus.triangle  = out_tri_q;
    assign bus.color     = out_color_q;
    assign bus.tri_ready = tri_ready_q;
    assign busy          = (word_cnt_q != 2'd0) || asm_full_q || tri_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_triangle_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triangle_loader
//  Description : Directed and random-gap self-checking bench for
//                triangle_loader. Follows DEGENERATE_CULL_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_loader;

    logic clk = 1'b0;
    logic n_rst;
    logic busy;
`ifdef DEGENERATE_CULL_EN
    logic [15:0] cull_count;
`endif

    int checks   = 0;
    int failures = 0;

    triangle_loader_if #(.COLOR_BITS(24)) bus ();

    triangle_loader #(.COLOR_BITS(24)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus.slave),
        .busy       (busy)
`ifdef DEGENERATE_CULL_EN
        ,
        .cull_count (cull_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        bus.data_in    = w;
        bus.data_ready = 1'b1;
        #1;
        while (!bus.data_read && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 50) begin
            check("send_timeout", {127'd0, bus.data_read}, 128'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        bus.data_ready = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    task automatic read_one();
        bus.tri_read = 1'b1;
        step();
        bus.tri_read = 1'b0;
        #1;
    endtask

    logic [31:0]  words [400];
    logic [119:0] exp_q [$];
    logic [119:0] exp_v;

    initial begin
        int sent;
        int got;
        int cyc;

        n_rst          = 1'b0;
        bus.data_in    = 32'd0;
        bus.data_ready = 1'b0;
        bus.tri_read   = 1'b0;
        step();
        step();

        // ---------------- Reset state ----------------
        #1;
        check("rst_tri_ready", {127'd0, bus.tri_ready}, 128'd0);
        check("rst_busy",      {127'd0, busy}, 128'd0);
        check("rst_triangle",  {32'd0, bus.triangle}, 128'd0);
        check("rst_color",     {104'd0, bus.color}, 128'd0);
        check("rst_data_read0", {127'd0, bus.data_read}, 128'd0);
        bus.data_ready = 1'b1;
        #1;
        check("rst_data_read1", {127'd0, bus.data_read}, 128'd1);
        bus.data_ready = 1'b0;
`ifdef DEGENERATE_CULL_EN
        check("rst_cull_count", {112'd0, cull_count}, 128'd0);
`endif
        n_rst = 1'b1;
        step();

        // ---------------- 1: single packet ----------------
        send_packet(32'h0040_1005, 32'h0C80_2010, 32'h0500_A020, 32'h00FF_8800);
        check("t1_tri_ready", {127'd0, bus.tri_ready}, 128'd1);
        check("t1_triangle", {32'd0, bus.triangle}, {32'd0, 32'h0500_A020, 32'h0C80_2010, 32'h0040_1005});
        check("t1_color", {104'd0, bus.color}, {104'd0, 24'hFF8800});
        check("t1_busy", {127'd0, busy}, 128'd1);
        read_one();
        check("t1_drained", {127'd0, bus.tri_ready}, 128'd0);
        check("t1_idle_busy", {127'd0, busy}, 128'd0);

        // ---------------- 2: backpressure ----------------
        send_packet(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h44AA_BBCC);
        send_packet(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8812_3456);
        bus.data_in    = 32'h9999_9999;
        bus.data_ready = 1'b1;
        #1;
        check("t2_stall", {127'd0, bus.data_read}, 128'd0);
        step();
        step();
        check("t2_stall_hold", {127'd0, bus.data_read}, 128'd0);
        check("t2_asm_full", {127'd0, dut.asm_full_q}, 128'd1);
        check("t2_out_a", {32'd0, bus.triangle}, {32'd0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        check("t2_color_a", {104'd0, bus.color}, {104'd0, 24'hAABBCC});
        bus.tri_read = 1'b1;
        step();
        bus.tri_read = 1'b0;
        #1;
        check("t2_ready_kept", {127'd0, bus.tri_ready}, 128'd1);
        check("t2_out_b", {32'd0, bus.triangle}, {32'd0, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555});
        check("t2_color_b", {104'd0, bus.color}, {104'd0, 24'h123456});
        check("t2_resume", {127'd0, bus.data_read}, 128'd1);
        send_packet(32'h9999_9999, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h00C0_FFEE);
        check("t2_hold_b", {32'd0, bus.triangle}, {32'd0, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555});
        read_one();
        check("t2_out_c", {32'd0, bus.triangle}, {32'd0, 32'hBBBB_BBBB, 32'hAAAA_AAAA, 32'h9999_9999});
        check("t2_color_c", {104'd0, bus.color}, {104'd0, 24'hC0FFEE});
        read_one();
        check("t2_empty", {127'd0, bus.tri_ready}, 128'd0);

        // ---------------- 3: completion and read on the same edge ----------------
        send_packet(32'h0100_1001, 32'h0200_2002, 32'h0300_3003, 32'h0011_1111);
        send_word(32'h0400_4004);
        send_word(32'h0500_5005);
        send_word(32'h0600_6006);
        bus.data_in    = 32'h0022_2222;
        bus.data_ready = 1'b1;
        bus.tri_read   = 1'b1;
        #1;
        check("t3_accept", {127'd0, bus.data_read}, 128'd1);
        step();
        bus.data_ready = 1'b0;
        bus.tri_read   = 1'b0;
        #1;
        check("t3_no_gap", {127'd0, bus.tri_ready}, 128'd1);
        check("t3_out_p2", {32'd0, bus.triangle}, {32'd0, 32'h0600_6006, 32'h0500_5005, 32'h0400_4004});
        check("t3_color_p2", {104'd0, bus.color}, {104'd0, 24'h222222});
        read_one();
        check("t3_empty", {127'd0, bus.tri_ready}, 128'd0);

        // ---------------- 4: reset mid-packet ----------------
        send_word(32'hDEAD_0001);
        send_word(32'hDEAD_0002);
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        #1;
        check("t4_busy", {127'd0, busy}, 128'd0);
        check("t4_triangle", {32'd0, bus.triangle}, 128'd0);
        send_packet(32'h0A00_1000, 32'h0B00_2000, 32'h0C00_3000, 32'h0012_3123);
        check("t4_ready", {127'd0, bus.tri_ready}, 128'd1);
        check("t4_out", {32'd0, bus.triangle}, {32'd0, 32'h0C00_3000, 32'h0B00_2000, 32'h0A00_1000});
        read_one();

        // ---------------- 5: degenerate packet ----------------
        send_packet(32'h0040_1005, 32'h0C80_2010, 32'h0040_1009, 32'h0000_0001);
`ifdef DEGENERATE_CULL_EN
        step();
        check("t5_no_ready", {127'd0, bus.tri_ready}, 128'd0);
        check("t5_cull_count", {112'd0, cull_count}, 128'd1);
        check("t5_busy", {127'd0, busy}, 128'd0);
        send_packet(32'h0040_1005, 32'h0C80_2010, 32'h0500_A020, 32'h0000_0002);
        check("t5_valid_ready", {127'd0, bus.tri_ready}, 128'd1);
        check("t5_valid_out", {32'd0, bus.triangle}, {32'd0, 32'h0500_A020, 32'h0C80_2010, 32'h0040_1005});
        check("t5_valid_color", {104'd0, bus.color}, 128'd2);
        read_one();
`else
        check("t5_fwd_ready", {127'd0, bus.tri_ready}, 128'd1);
        check("t5_fwd_out", {32'd0, bus.triangle}, {32'd0, 32'h0040_1009, 32'h0C80_2010, 32'h0040_1005});
        check("t5_fwd_color", {104'd0, bus.color}, 128'd1);
        read_one();
`endif
        check("t5_empty", {127'd0, bus.tri_ready}, 128'd0);

        // ---------------- 6: random gaps, 100 packets ----------------
        for (int p = 0; p < 100; p++) begin
            for (int k = 0; k < 4; k++) begin
                words[4*p+k] = $urandom;
            end
            // Distinct x per vertex keeps every packet non-degenerate.
            words[4*p+0][31:22] = 10'd1;
            words[4*p+1][31:22] = 10'd2;
            words[4*p+2][31:22] = 10'd3;
        end
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 100 && cyc < 20000) begin
            bus.data_ready = (sent < 400) && ($urandom_range(0, 3) != 0);
            bus.data_in    = (sent < 400) ? words[sent] : 32'd0;
            bus.tri_read   = ($urandom_range(0, 2) == 0);
            #1;
            if (bus.tri_ready && bus.tri_read) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", {127'd0, bus.tri_ready}, 128'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_tri", {8'd0, bus.triangle, bus.color}, {8'd0, exp_v});
                end
                got++;
            end
            if (bus.data_ready && bus.data_read) begin
                if (sent % 4 == 3) begin
                    exp_q.push_back({words[sent-1], words[sent-2], words[sent-3], words[sent][23:0]});
                end
                sent++;
            end
            step();
            cyc++;
        end
        bus.data_ready = 1'b0;
        bus.tri_read   = 1'b0;
        check("rand_count", 128'(got), 128'd100);
        step();
        check("rand_drain_ready", {127'd0, bus.tri_ready}, 128'd0);
        check("rand_drain_busy", {127'd0, busy}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
